mult_share_arbiter: RTL and testbench



---
 rtl/mult_share_arbiter_pkg.sv | 26 ++
 rtl/mult_share_arbiter_tag_delay_line.sv | 46 ++++
 rtl/mult_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter: tag layout,
// channel-width derivation and default operand widths.
package mult_share_arbiter_pkg;

    localparam int DEF_WIDTH_A = 24;
    localparam int DEF_WIDTH_B = 18;
    localparam int CH_W_MAX    = 4;

    // Channel index width; never below one bit so a tag always carries a channel field.
    function automatic int ch_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Valid must stay the MSB: the delay line reports occupancy from that bit.
    typedef struct packed {
        logic                valid;
        logic [CH_W_MAX-1:0] ch;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/mult_share_arbiter_tag_delay_line.sv
// Fixed-depth shift register with synchronous flush; reports which stages hold
// an entry whose MSB (valid flag) is set.
module tag_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 5
) (
    input  logic             clk_i,
    input  logic             flush_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output logic [DEPTH-1:0] live_o
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Next-state: new entry at stage 0, everything else moves one stage on.
    always_comb begin
        stage_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers, cleared by flush.
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Output tap and per-stage occupancy.
    always_comb begin
        dout_o = stage_q[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            live_o[i] = stage_q[i][W-1];
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin time-sharing of one pipelined signed multiplier between N_CH
// requesters; channel tags ride alongside the multiplier so products return home.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int WIDTH_A     = DEF_WIDTH_A,
    parameter  int WIDTH_B     = DEF_WIDTH_B,
    parameter  int MUL_LATENCY = 1,
    localparam int CH_W        = ch_width(N_CH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [N_CH-1:0]           req_valid_i,
    output logic [N_CH-1:0]           req_ready_o,
    input  logic [N_CH*WIDTH_A-1:0]   req_a_i,
    input  logic [N_CH*WIDTH_B-1:0]   req_b_i,
    output logic [WIDTH_A-1:0]        mul_a_o,
    output logic [WIDTH_B-1:0]        mul_b_o,
    input  logic [WIDTH_A+WIDTH_B-1:0] mul_c_i,
    output logic [N_CH-1:0]           res_valid_o,
    output logic [WIDTH_A+WIDTH_B-1:0] res_data_o,
    output logic [CH_W-1:0]           res_ch_o,
    output logic                      busy_o,
    output logic [31:0]               issue_count_o
);

    localparam int P_W = WIDTH_A + WIDTH_B;

    logic [CH_W-1:0]        last_q, last_d;
    logic [CH_W-1:0]        cand_s, gnt_idx_s;
    logic                   gnt_found_s, hs_s;
    logic [WIDTH_A-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH_B-1:0]     mul_b_q, mul_b_d;
    tag_t                   issue_tag_q, issue_tag_d, pipe_out_s;
    logic [TAG_W-1:0]       pipe_out_raw_s;
    logic [MUL_LATENCY-1:0] pipe_live_s;
    logic [N_CH-1:0]        res_valid_q, res_valid_d;
    logic [P_W-1:0]         res_data_q, res_data_d;
    logic [CH_W-1:0]        res_ch_q, res_ch_d;
    logic                   busy_q, busy_d;
    logic [31:0]            count_q, count_d;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = last_q;
        cand_s      = last_q;
        for (int off = 1; off <= N_CH; off++) begin
            cand_s = CH_W'((int'(last_q) + off) % N_CH);
            if (!gnt_found_s && req_valid_i[cand_s] && enable_i && !rst_i) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // One-hot grant vector.
    always_comb begin
        req_ready_o = {N_CH{1'b0}};
        if (gnt_found_s) begin
            req_ready_o[gnt_idx_s] = 1'b1;
        end else begin
            req_ready_o = {N_CH{1'b0}};
        end
    end

    assign hs_s = |(req_ready_o & req_valid_i);

    // Issue stage: capture operands and launch a tag on a handshake.
    always_comb begin
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        issue_tag_d = tag_t'({TAG_W{1'b0}});
        last_d      = last_q;
        count_d     = count_q;
        if (hs_s) begin
            mul_a_d           = req_a_i[gnt_idx_s*WIDTH_A +: WIDTH_A];
            mul_b_d           = req_b_i[gnt_idx_s*WIDTH_B +: WIDTH_B];
            issue_tag_d.valid = 1'b1;
            issue_tag_d.ch    = CH_W_MAX'(gnt_idx_s);
            last_d            = gnt_idx_s;
            count_d           = count_q + 32'd1;
        end else begin
            issue_tag_d.valid = 1'b0;
        end
    end

    // The delay line matches the multiplier latency behind the operand register.
    tag_delay_line #(
        .DEPTH (MUL_LATENCY),
        .W     (TAG_W)
    ) u_tag_pipe (
        .clk_i   (clk_i),
        .flush_i (rst_i),
        .din_i   (issue_tag_q),
        .dout_o  (pipe_out_raw_s),
        .live_o  (pipe_live_s)
    );

    assign pipe_out_s = tag_t'(pipe_out_raw_s);

    // Return stage: steer the product to its channel; data/channel hold otherwise.
    always_comb begin
        res_valid_d = {N_CH{1'b0}};
        res_data_d  = res_data_q;
        res_ch_d    = res_ch_q;
        if (pipe_out_s.valid) begin
            res_valid_d[CH_W'(pipe_out_s.ch)] = 1'b1;
            res_data_d                        = mul_c_i;
            res_ch_d                          = CH_W'(pipe_out_s.ch);
        end else begin
            res_valid_d = {N_CH{1'b0}};
        end
    end

    // Busy reflects every tag that will be in flight after this edge.
    always_comb begin
        busy_d = issue_tag_d.valid | issue_tag_q.valid | (|pipe_live_s);
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q      <= CH_W'(N_CH - 1);
            mul_a_q     <= {WIDTH_A{1'b0}};
            mul_b_q     <= {WIDTH_B{1'b0}};
            issue_tag_q <= tag_t'({TAG_W{1'b0}});
            res_valid_q <= {N_CH{1'b0}};
            res_data_q  <= {P_W{1'b0}};
            res_ch_q    <= {CH_W{1'b0}};
            busy_q      <= 1'b0;
            count_q     <= 32'd0;
        end else begin
            last_q      <= last_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            issue_tag_q <= issue_tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ch_q    <= res_ch_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    assign mul_a_o       = mul_a_q;
    assign mul_b_o       = mul_b_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_ch_o      = res_ch_q;
    assign busy_o        = busy_q;
    assign issue_count_o = count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a registered (latency 1) multiplier model.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [95:0] req_a;
    logic [71:0] req_b;
    logic [23:0] mul_a;
    logic [17:0] mul_b;
    logic signed [41:0] mul_c;
    logic [3:0]  res_valid;
    logic [41:0] res_data;
    logic [1:0]  res_ch;
    logic        busy;
    logic [31:0] count;

    int total = 0;
    int bad   = 0;
    logic [41:0] e42;

    mult_share_arbiter #(
        .N_CH(4), .WIDTH_A(24), .WIDTH_B(18), .MUL_LATENCY(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_c_i(mul_c),
        .res_valid_o(res_valid), .res_data_o(res_data), .res_ch_o(res_ch),
        .busy_o(busy), .issue_count_o(count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        mul_c <= $signed(mul_a) * $signed(mul_b);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int ch, input logic [23:0] a, input logic [17:0] b);
        req_a[ch*24 +: 24] = a;
        req_b[ch*18 +: 18] = b;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req_valid = 4'b1111;
        req_a = 96'd0; req_b = 72'd0;

        // Reset held three cycles with every channel requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'h0);
            chk("rst_resv", 64'(res_valid), 64'h0);
        end
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_mula", 64'(mul_a), 64'h0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;

        // Single op on ch2: 3 * -5.
        req_valid = 4'b0100;
        set_op(2, 24'd3, -18'sd5);
        @(negedge clk); chk("single_ready", 64'(req_ready), 64'h4);
        tick(); req_valid = 4'b0000;
        @(negedge clk); chk("single_busy", 64'(busy), 64'h1);
        chk("single_mula", 64'(mul_a), 64'h3);
        tick(); tick();
        @(negedge clk);
        e42 = -42'sd15;
        chk("single_resv", 64'(res_valid), 64'h4);
        chk("single_data", 64'(res_data), 64'(e42));
        chk("single_ch", 64'(res_ch), 64'h2);
        tick();
        @(negedge clk);
        chk("single_resv_off", 64'(res_valid), 64'h0);
        chk("single_hold", 64'(res_data), 64'(e42));
        chk("single_idle", 64'(busy), 64'h0);
        tick();

        // Full load: strict rotation, products 10,20,30,40 in issue order.
        do_reset();
        for (int k = 0; k < 4; k++) set_op(k, 24'(k + 1), 18'd10);
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 8) chk("full_grant", 64'(req_ready), 64'(1 << (c % 4)));
            if (c >= 3 && c < 11) begin
                chk("full_resv", 64'(res_valid), 64'(1 << ((c - 3) % 4)));
                chk("full_data", 64'(res_data), 64'((((c - 3) % 4) + 1) * 10));
            end
            tick();
        end
        chk("full_count", 64'(count), 64'd8);

        // Sparse: only ch1/ch3 alternate, then ch0 follows ch3.
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'b1010;
            @(negedge clk);
            chk("sparse_grant", 64'(req_ready), (c % 2 == 0) ? 64'h2 : 64'h8);
            tick();
        end
        req_valid = 4'b1011;
        @(negedge clk); chk("sparse_ch0", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0000;
        repeat (4) tick();

        // Operand extremes back-to-back on ch0.
        do_reset();
        req_valid = 4'b0001;
        set_op(0, 24'h800000, 18'h20000);
        @(negedge clk); chk("ext_grant0", 64'(req_ready), 64'h1);
        tick();
        set_op(0, 24'h7FFFFF, 18'h20000);
        @(negedge clk); chk("ext_grant1", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0000;
        tick();
        @(negedge clk);
        chk("ext_min_resv", 64'(res_valid), 64'h1);
        chk("ext_min_data", 64'(res_data), 64'd1099511627776);
        tick();
        @(negedge clk);
        e42 = -42'sd1099511496704;
        chk("ext_max_resv", 64'(res_valid), 64'h1);
        chk("ext_max_data", 64'(res_data), 64'(e42));
        tick();

        // Enable dropped after one issue: no new grants, in-flight op still delivered.
        do_reset();
        req_valid = 4'b0010;
        set_op(1, 24'd7, 18'd6);
        @(negedge clk); chk("en_grant", 64'(req_ready), 64'h2);
        tick();
        for (int c = 1; c <= 5; c++) begin
            en = 1'b0;
            req_valid = 4'b1111;
            @(negedge clk);
            chk("en_off_ready", 64'(req_ready), 64'h0);
            if (c == 3) begin
                chk("en_resv", 64'(res_valid), 64'h2);
                chk("en_data", 64'(res_data), 64'd42);
            end
            tick();
        end
        en = 1'b1;
        req_valid = 4'b0000;
        chk("en_count", 64'(count), 64'd1);

        // Reset one cycle after an issue: the op is discarded.
        do_reset();
        req_valid = 4'b1000;
        set_op(3, 24'd5, 18'd5);
        @(negedge clk); chk("rmid_grant", 64'(req_ready), 64'h8);
        tick();
        rst = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk); chk("rmid_rst_ready", 64'(req_ready), 64'h0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk("rmid_resv", 64'(res_valid), 64'h0);
            chk("rmid_busy", 64'(busy), 64'h0);
            tick();
        end
        chk("rmid_count", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
